exec_cont: RTL and testbench

- Execute-side controller; consumer of the fetch controller's decoded-instruction interface (opcode, src1, src2, dst, ready, finished).
- Accepts one decoded instruction per handshake and reads two operands from data memory through a single synchronous-read port.
- Computes the result, writes it to dst, then advances pc, which feeds the fetch side.
- Stops permanently on a halt instruction.

---
 rtl/exec_cont.sv | 89 ++++++++
 tb/tb_exec_cont.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/exec_cont.sv
// exec_cont: execute-side controller; reads two operands, writes the result, advances pc, halts permanently.
module exec_cont #(
  parameter int INS_MEMORY_SIZE = 32,
  parameter int DATA_MEMORY_SIZE = 64,
  parameter int DATA_WIDTH = 8,
  parameter int SKIP_EDGES = 1,
  localparam int PW = $clog2(INS_MEMORY_SIZE),
  localparam int AW = $clog2(DATA_MEMORY_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            opcode,
  input  logic [AW-1:0]         src1,
  input  logic [AW-1:0]         src2,
  input  logic [AW-1:0]         dst,
  input  logic                  ready,
  input  logic                  finished,
  output logic [PW-1:0]         pc,
  output logic [AW-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  halted
);
  localparam int SW = $clog2(SKIP_EDGES + 2);
  typedef enum logic [2:0] {IDLE, RD1, RD2, CAP, WB, NEXT, HALT} state_t;
  state_t state, next;
  logic ready_q, rise, accept;
  logic [SW-1:0] skip;
  logic [1:0] op_q;
  logic [AW-1:0] src2_q, dst_q;
  logic [DATA_WIDTH-1:0] op1, result;
  assign rise = ready & ~ready_q;
  assign accept = (state == IDLE) && rise && (skip == '0);
  assign busy = !(state inside {IDLE, HALT});
  assign halted = (state == HALT);
  // second operand is taken straight from the read port while in CAP
  assign result = (op_q == 2'b01) ? op1 + mem_rdata :
                  (op_q == 2'b10) ? op1 - mem_rdata : op1 * mem_rdata;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = accept ? ((opcode == 2'b00 || finished) ? HALT : RD1) : IDLE;
      RD1:  next = RD2;
      RD2:  next = CAP;
      CAP:  next = WB;
      WB:   next = NEXT;
      NEXT: next = IDLE;
      default: next = state;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  // registered outputs are loaded one cycle ahead so they are valid for the whole state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b0;
      skip <= '0;
      pc <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_we <= 1'b0;
      op_q <= '0;
      src2_q <= '0;
      dst_q <= '0;
      op1 <= '0;
    end else begin
      ready_q <= ready;
      mem_we <= (state == CAP);
      if (accept) begin
        op_q <= opcode;
        src2_q <= src2;
        dst_q <= dst;
      end
      if (accept && next == RD1) mem_addr <= src1;
      if (state == IDLE && rise && skip != '0) skip <= skip - 1'b1;
      if (state == RD1) mem_addr <= src2_q;
      if (state == RD2) op1 <= mem_rdata;
      if (state == CAP) begin
        mem_addr <= dst_q;
        mem_wdata <= result;
      end
      if (state == WB) pc <= (pc == PW'(INS_MEMORY_SIZE - 1)) ? '0 : pc + 1'b1;
      if (state == NEXT) skip <= SW'(SKIP_EDGES);
    end
  end
endmodule

// File: tb/tb_exec_cont.sv
// tb_exec_cont: randomized self-checking bench for exec_cont with a data-memory model and arithmetic reference.
module tb_exec_cont;
  logic clk = 0, reset = 1, ready = 0, finished = 0;
  logic [1:0] opcode = 0;
  logic [5:0] src1 = 0, src2 = 0, dst = 0;
  logic [4:0] pc;
  logic [5:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic mem_we, busy, halted;
  logic [7:0] mem [64];
  logic [7:0] ref_mem [64];
  int checks = 0, failures = 0, pc_exp = 0;

  always #5 clk = ~clk;

  exec_cont dut (
    .clk(clk), .reset(reset), .opcode(opcode), .src1(src1), .src2(src2), .dst(dst),
    .ready(ready), .finished(finished), .pc(pc), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy), .halted(halted)
  );

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  function automatic logic [7:0] model(input int op, input int a, input int b);
    int r;
    r = (op == 1) ? a + b : (op == 2) ? a - b + 256 : a * b;
    return 8'(r % 256);
  endfunction

  task automatic poke(input int a, input int v);
    mem[a] <= 8'(v);
    ref_mem[a] = 8'(v);
  endtask

  task automatic do_reset;
    reset = 1;
    ready = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    pc_exp = 0;
    @(negedge clk);
  endtask

  task automatic burn_skip;
    @(negedge clk) ready = 1;
    @(negedge clk) ready = 0;
    @(negedge clk);
  endtask

  task automatic run_instr(input int op, input int s1, input int s2, input int d, input logic fin,
                           output int lat, output logic [5:0] wa, output logic [7:0] wd,
                           output int pc_lat, output int bc);
    logic [4:0] pc0;
    @(negedge clk);
    pc0 = pc;
    opcode = 2'(op); src1 = 6'(s1); src2 = 6'(s2); dst = 6'(d); finished = fin; ready = 1;
    lat = -1; pc_lat = -1; bc = 0; wa = '0; wd = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      ready = 0;
      if (mem_we && lat < 0) begin lat = i; wa = mem_addr; wd = mem_wdata; end
      if (pc !== pc0 && pc_lat < 0) pc_lat = i;
      if (busy) bc++;
    end
    finished = 0;
  endtask

  task automatic test_reset;
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (pc !== 5'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", pc); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", mem_we); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (mem_addr !== 6'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", mem_addr); end
    checks++; if (mem_wdata !== 8'd0) begin failures++; $display("FAIL reset_wdata got=%0d exp=0", mem_wdata); end
    reset = 0;
    pc_exp = 0;
    @(negedge clk);
  endtask

  task automatic test_add;
    int lat, pl, bc; logic [5:0] wa; logic [7:0] wd;
    poke(1, 5); poke(2, 3);
    run_instr(1, 1, 2, 4, 0, lat, wa, wd, pl, bc);
    pc_exp = 1;
    checks++; if (lat !== 4) begin failures++; $display("FAIL add_we_latency got=%0d exp=4", lat); end
    checks++; if (wa !== 6'd4) begin failures++; $display("FAIL add_addr got=%0d exp=4", wa); end
    checks++; if (wd !== 8'd8) begin failures++; $display("FAIL add_wdata got=%0d exp=8", wd); end
    checks++; if (pl !== 5) begin failures++; $display("FAIL add_pc_latency got=%0d exp=5", pl); end
    checks++; if (pc !== 5'd1) begin failures++; $display("FAIL add_pc got=%0d exp=1", pc); end
    checks++; if (bc !== 5) begin failures++; $display("FAIL add_busy_cycles got=%0d exp=5", bc); end
    checks++; if (mem[4] !== 8'd8) begin failures++; $display("FAIL add_mem got=%0d exp=8", mem[4]); end
  endtask

  task automatic test_sub_mul;
    int lat, pl, bc; logic [5:0] wa; logic [7:0] wd;
    burn_skip; poke(1, 3); poke(2, 5);
    run_instr(2, 1, 2, 6, 0, lat, wa, wd, pl, bc);
    pc_exp++;
    checks++; if (wd !== 8'hFE || wa !== 6'd6) begin failures++; $display("FAIL sub_wrap got=%h@%0d exp=fe@6", wd, wa); end
    burn_skip; poke(1, 20); poke(2, 13);
    run_instr(3, 1, 2, 5, 0, lat, wa, wd, pl, bc);
    pc_exp++;
    checks++; if (wd !== 8'h04 || wa !== 6'd5) begin failures++; $display("FAIL mul_trunc got=%h@%0d exp=04@5", wd, wa); end
    checks++; if (pc !== 5'(pc_exp)) begin failures++; $display("FAIL submul_pc got=%0d exp=%0d", pc, pc_exp); end
  endtask

  task automatic test_alias;
    int lat, pl, bc; logic [5:0] wa; logic [7:0] wd;
    burn_skip; poke(7, 9); poke(1, 1);
    run_instr(1, 7, 1, 7, 0, lat, wa, wd, pl, bc);
    pc_exp++;
    checks++; if (mem[7] !== 8'd10) begin failures++; $display("FAIL alias_mem got=%0d exp=10", mem[7]); end
    ref_mem[7] = 8'd10;
  endtask

  task automatic test_random;
    int lat, pl, bc, op, s1, s2, d; logic [5:0] wa; logic [7:0] wd, exp;
    for (int n = 0; n < 12; n++) begin
      op = $urandom_range(1, 3); s1 = $urandom_range(0, 63); s2 = $urandom_range(0, 63); d = $urandom_range(0, 63);
      poke(s1, $urandom_range(0, 255)); poke(s2, $urandom_range(0, 255));
      exp = model(op, ref_mem[s1], ref_mem[s2]);
      burn_skip;
      run_instr(op, s1, s2, d, 0, lat, wa, wd, pl, bc);
      ref_mem[d] = exp;
      pc_exp = (pc_exp + 1) % 32;
      checks++; if (lat !== 4 || wa !== 6'(d) || wd !== exp) begin failures++; $display("FAIL rand_write n=%0d got=%0d@%0d lat=%0d exp=%0d@%0d lat=4", n, wd, wa, lat, exp, d); end
      checks++; if (pc !== 5'(pc_exp) || mem[d] !== exp) begin failures++; $display("FAIL rand_state n=%0d pc=%0d mem=%0d exp pc=%0d mem=%0d", n, pc, mem[d], pc_exp, exp); end
    end
  endtask

  task automatic test_skip;
    int pulses = 0; logic [7:0] exp;
    poke(10, $urandom_range(0, 255)); poke(11, $urandom_range(0, 255));
    exp = model(1, ref_mem[10], ref_mem[11]);
    opcode = 2'b01; src1 = 10; src2 = 11; dst = 12;
    @(negedge clk) ready = 1;
    @(negedge clk) ready = 0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL skip_first_edge busy=%b exp=0", busy); end
    @(negedge clk) ready = 1;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL skip_second_edge busy=%b exp=1", busy); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_we) pulses++;
    end
    ready = 0;
    ref_mem[12] = exp;
    pc_exp = (pc_exp + 1) % 32;
    checks++; if (pulses !== 1) begin failures++; $display("FAIL skip_held_ready pulses=%0d exp=1", pulses); end
    checks++; if (pc !== 5'(pc_exp) || mem[12] !== exp) begin failures++; $display("FAIL skip_result pc=%0d mem=%0d exp pc=%0d mem=%0d", pc, mem[12], pc_exp, exp); end
    @(negedge clk);
  endtask

  task automatic test_pc_wrap;
    int lat, pl, bc, guard = 0; logic [5:0] wa; logic [7:0] wd;
    while (pc_exp != 31 && guard < 40) begin
      burn_skip;
      run_instr(1, 0, 0, 63, 0, lat, wa, wd, pl, bc);
      ref_mem[63] = model(1, ref_mem[0], ref_mem[0]);
      pc_exp++;
      guard++;
    end
    checks++; if (pc !== 5'd31) begin failures++; $display("FAIL wrap_pre got=%0d exp=31", pc); end
    burn_skip;
    run_instr(1, 0, 0, 63, 0, lat, wa, wd, pl, bc);
    pc_exp = 0;
    checks++; if (pc !== 5'd0) begin failures++; $display("FAIL wrap_pc got=%0d exp=0", pc); end
  endtask

  task automatic test_reset_wb;
    int lat, pl, bc; logic [5:0] wa; logic [7:0] wd;
    burn_skip; poke(20, 1); poke(21, 2); poke(22, 77);
    @(negedge clk);
    opcode = 2'b01; src1 = 20; src2 = 21; dst = 22; ready = 1;
    @(negedge clk) ready = 0;
    repeat (3) @(negedge clk);
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL rst_wb_reach we=%b exp=1", mem_we); end
    reset = 1;
    #1;
    checks++; if (mem_we !== 1'b0 || pc !== 5'd0 || busy !== 1'b0) begin failures++; $display("FAIL rst_wb_async we=%b pc=%0d busy=%b exp 0/0/0", mem_we, pc, busy); end
    @(negedge clk);
    @(negedge clk) reset = 0;
    pc_exp = 0;
    @(negedge clk);
    checks++; if (mem[22] !== 8'd77) begin failures++; $display("FAIL rst_wb_nowrite got=%0d exp=77", mem[22]); end
    run_instr(1, 20, 21, 23, 0, lat, wa, wd, pl, bc);
    pc_exp = 1;
    ref_mem[23] = 8'd3;
    checks++; if (lat !== 4 || wd !== 8'd3 || pc !== 5'd1) begin failures++; $display("FAIL rst_wb_idle lat=%0d wd=%0d pc=%0d exp 4/3/1", lat, wd, pc); end
  endtask

  task automatic test_halt;
    int lat, pl, bc; logic [5:0] wa; logic [7:0] wd;
    do_reset;
    run_instr(1, 1, 2, 30, 1, lat, wa, wd, pl, bc);
    checks++; if (halted !== 1'b1 || lat !== -1 || pc !== 5'd0 || bc !== 0) begin failures++; $display("FAIL halt_finished halted=%b lat=%0d pc=%0d busy=%0d exp 1/-1/0/0", halted, lat, pc, bc); end
    checks++; if (mem[30] !== ref_mem[30]) begin failures++; $display("FAIL halt_finished_mem got=%0d exp=%0d", mem[30], ref_mem[30]); end
    do_reset;
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_cleared got=%b exp=0", halted); end
    run_instr(1, 1, 2, 31, 0, lat, wa, wd, pl, bc);
    burn_skip;
    run_instr(0, 1, 2, 31, 0, lat, wa, wd, pl, bc);
    checks++; if (halted !== 1'b1 || pc !== 5'd1 || lat !== -1) begin failures++; $display("FAIL halt_opcode halted=%b pc=%0d lat=%0d exp 1/1/-1", halted, pc, lat); end
    for (int n = 0; n < 3; n++) begin
      run_instr(1, 1, 2, 31, 0, lat, wa, wd, pl, bc);
      checks++; if (lat !== -1 || pc !== 5'd1 || halted !== 1'b1 || bc !== 0) begin failures++; $display("FAIL halt_sticky n=%0d lat=%0d pc=%0d halted=%b busy=%0d", n, lat, pc, halted, bc); end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin mem[i] <= 8'd0; ref_mem[i] = 8'd0; end
    test_reset;
    test_add;
    test_sub_mul;
    test_alias;
    test_random;
    test_skip;
    test_pc_wrap;
    test_reset_wb;
    test_halt;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout reached before summary");
    $fatal(1);
  end
endmodule
